// File: rtl/excp_ctrl_pkg.sv
// Shared definitions for the exception/interrupt arbitration stage:
// exception codes, sequencing state encoding and the default vector.
package excp_pkg;

  typedef logic [4:0] exc_code_t;

  localparam exc_code_t EXC_INT  = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;
  localparam exc_code_t EXC_ADES = 5'd5;
  localparam exc_code_t EXC_SYS  = 5'd8;
  localparam exc_code_t EXC_BP   = 5'd9;
  localparam exc_code_t EXC_RI   = 5'd10;
  localparam exc_code_t EXC_OV   = 5'd12;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } excp_state_e;

endpackage

// File: rtl/excp_ctrl_if.sv
// MEM-stage, CP0 and fetch-redirect signals seen by excp_ctrl.
// slave is the arbitration stage; master is the surrounding pipeline/CP0.
interface excp_ctrl_if;
  logic [5:0]  ext_int;
  logic        mem_valid;
  logic        mem_stall;
  logic [31:0] mem_pc;
  logic [31:0] mem_dvaddr;
  logic        mem_is_bd;
  logic        mem_adel_if;
  logic        mem_ri;
  logic        mem_ov;
  logic        mem_sys;
  logic        mem_bp;
  logic        mem_adel_ld;
  logic        mem_ades;
  logic        mem_eret;
  logic        is_ie;
  logic        is_exl;
  logic [7:0]  int_mask;
  logic [1:0]  soft_int;
  logic [31:0] errorpc;
  logic [5:0]  hardware_int;
  logic        is_exception;
  logic        is_bd;
  logic        we_badvaddr;
  logic        is_excep_return;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] badvaddr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  ext_int, mem_valid, mem_stall, mem_pc, mem_dvaddr, mem_is_bd,
           mem_adel_if, mem_ri, mem_ov, mem_sys, mem_bp, mem_adel_ld,
           mem_ades, mem_eret, is_ie, is_exl, int_mask, soft_int, errorpc,
           redirect_ready,
    output hardware_int, is_exception, is_bd, we_badvaddr, is_excep_return,
           exc_code, exc_pc, badvaddr, flush, redirect_valid, redirect_pc
  );

  modport master (
    output ext_int, mem_valid, mem_stall, mem_pc, mem_dvaddr, mem_is_bd,
           mem_adel_if, mem_ri, mem_ov, mem_sys, mem_bp, mem_adel_ld,
           mem_ades, mem_eret, is_ie, is_exl, int_mask, soft_int, errorpc,
           redirect_ready,
    input  hardware_int, is_exception, is_bd, we_badvaddr, is_excep_return,
           exc_code, exc_pc, badvaddr, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/excp_ctrl_int_sync.sv
// Two-flop synchroniser for asynchronous level inputs, async reset to 0.
module int_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
    end
  end

  assign sync_out = sync2;

endmodule

// File: rtl/excp_ctrl.sv
// Exception/interrupt arbitration ahead of CP0: prioritises causes, emits
// one-cycle CP0 commit strobes and sequences flush plus fetch redirect.
module excp_ctrl
  import excp_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  excp_ctrl_if.slave bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  excp_state_e state;
  logic [3:0]  flush_cnt;
  logic [5:0]  hw_int;
  logic        int_pend;
  logic        can_detect;
  logic        take_exc;
  exc_code_t   win_code;
  logic        win_bad_we;
  logic [31:0] win_bad_addr;

  logic        is_exception_q, is_bd_q, we_badvaddr_q, is_excep_return_q;
  exc_code_t   exc_code_q;
  logic [31:0] exc_pc_q, badvaddr_q, redirect_pc_q;
  logic        flush_q, redirect_valid_q;

  int_sync #(.WIDTH(6)) u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.ext_int),
    .sync_out (hw_int)
  );

  // Fixed-priority cause selection; interrupts outrank every synchronous cause.
  always_comb begin
    int_pend     = (|({hw_int, bus.soft_int} & bus.int_mask)) & bus.is_ie & ~bus.is_exl;
    can_detect   = (state == IDLE) & bus.mem_valid & ~bus.mem_stall;
    take_exc     = 1'b1;
    win_code     = EXC_INT;
    win_bad_we   = 1'b0;
    win_bad_addr = bus.mem_pc;
    if (int_pend) begin
      win_code = EXC_INT;
    end else if (bus.mem_adel_if) begin
      win_code   = EXC_ADEL;
      win_bad_we = 1'b1;
    end else if (bus.mem_ri) begin
      win_code = EXC_RI;
    end else if (bus.mem_ov) begin
      win_code = EXC_OV;
    end else if (bus.mem_sys) begin
      win_code = EXC_SYS;
    end else if (bus.mem_bp) begin
      win_code = EXC_BP;
    end else if (bus.mem_adel_ld) begin
      win_code     = EXC_ADEL;
      win_bad_we   = 1'b1;
      win_bad_addr = bus.mem_dvaddr;
    end else if (bus.mem_ades) begin
      win_code     = EXC_ADES;
      win_bad_we   = 1'b1;
      win_bad_addr = bus.mem_dvaddr;
    end else begin
      take_exc = 1'b0;
    end
  end

  // Strobes default low every cycle so they can only pulse for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      flush_cnt         <= '0;
      is_exception_q    <= 1'b0;
      is_bd_q           <= 1'b0;
      we_badvaddr_q     <= 1'b0;
      is_excep_return_q <= 1'b0;
      exc_code_q        <= '0;
      exc_pc_q          <= '0;
      badvaddr_q        <= '0;
      flush_q           <= 1'b0;
      redirect_valid_q  <= 1'b0;
      redirect_pc_q     <= '0;
    end else begin
      is_exception_q    <= 1'b0;
      is_bd_q           <= 1'b0;
      we_badvaddr_q     <= 1'b0;
      is_excep_return_q <= 1'b0;
      case (state)
        IDLE: begin
          if (can_detect && take_exc) begin
            state          <= FLUSH;
            flush_cnt      <= FLUSH_LOAD;
            flush_q        <= 1'b1;
            is_exception_q <= 1'b1;
            is_bd_q        <= bus.mem_is_bd;
            we_badvaddr_q  <= win_bad_we;
            exc_code_q     <= win_code;
            exc_pc_q       <= bus.mem_is_bd ? bus.mem_pc - 32'd4 : bus.mem_pc;
            if (win_bad_we) badvaddr_q <= win_bad_addr;
            redirect_pc_q  <= EXC_VECTOR;
          end else if (can_detect && bus.mem_eret) begin
            state             <= FLUSH;
            flush_cnt         <= FLUSH_LOAD;
            flush_q           <= 1'b1;
            is_excep_return_q <= 1'b1;
            redirect_pc_q     <= bus.errorpc;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state            <= REDIRECT;
            redirect_valid_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        REDIRECT: begin
          if (redirect_valid_q && bus.redirect_ready) begin
            state            <= IDLE;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hardware_int    = hw_int;
  assign bus.is_exception    = is_exception_q;
  assign bus.is_bd           = is_bd_q;
  assign bus.we_badvaddr     = we_badvaddr_q;
  assign bus.is_excep_return = is_excep_return_q;
  assign bus.exc_code        = exc_code_q;
  assign bus.exc_pc          = exc_pc_q;
  assign bus.badvaddr        = badvaddr_q;
  assign bus.flush           = flush_q;
  assign bus.redirect_valid  = redirect_valid_q;
  assign bus.redirect_pc     = redirect_pc_q;

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed self-checking bench for excp_ctrl (FLUSH_CYCLES = 2); inputs are
// driven on the falling edge and outputs sampled on the falling edge.
module tb_excp_ctrl;

  localparam logic [7:0] F_NONE    = 8'h00;
  localparam logic [7:0] F_ADEL_IF = 8'h80;
  localparam logic [7:0] F_RI      = 8'h40;
  localparam logic [7:0] F_OV      = 8'h20;
  localparam logic [7:0] F_SYS     = 8'h10;
  localparam logic [7:0] F_BP      = 8'h08;
  localparam logic [7:0] F_ADEL_LD = 8'h04;
  localparam logic [7:0] F_ADES    = 8'h02;
  localparam logic [7:0] F_ERET    = 8'h01;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  excp_ctrl_if bus ();

  excp_ctrl #(
    .EXC_VECTOR   (32'hBFC0_0380),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] dvaddr,
                               input logic bd, input logic [7:0] flags);
    bus.mem_valid   = 1'b1;
    bus.mem_pc      = pc;
    bus.mem_dvaddr  = dvaddr;
    bus.mem_is_bd   = bd;
    bus.mem_adel_if = flags[7];
    bus.mem_ri      = flags[6];
    bus.mem_ov      = flags[5];
    bus.mem_sys     = flags[4];
    bus.mem_bp      = flags[3];
    bus.mem_adel_ld = flags[2];
    bus.mem_ades    = flags[1];
    bus.mem_eret    = flags[0];
  endtask

  task automatic clearMem();
    applyStimulus(32'h0, 32'h0, 1'b0, F_NONE);
    bus.mem_valid = 1'b0;
  endtask

  function automatic logic [127:0] allOutputs();
    return 128'({bus.hardware_int, bus.is_exception, bus.is_bd, bus.we_badvaddr,
                 bus.is_excep_return, bus.exc_code, bus.exc_pc, bus.badvaddr,
                 bus.flush, bus.redirect_valid, bus.redirect_pc});
  endfunction

  // Called on the falling edge of the first flush cycle with redirect_ready = 1.
  task automatic expectRedirect(input string tag, input logic [31:0] pc);
    @(negedge clk);
    checkOutput({tag, "_strobe_drop"}, 128'(bus.is_exception | bus.is_excep_return), 128'(0));
    checkOutput({tag, "_valid_early"}, 128'(bus.redirect_valid), 128'(0));
    @(negedge clk);
    checkOutput({tag, "_valid"}, 128'(bus.redirect_valid), 128'(1));
    checkOutput({tag, "_pc"}, 128'(bus.redirect_pc), 128'(pc));
    checkOutput({tag, "_flush_hs"}, 128'(bus.flush), 128'(1));
    @(negedge clk);
    checkOutput({tag, "_idle"}, 128'({bus.flush, bus.redirect_valid}), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    bus.ext_int        = 6'h00;
    bus.mem_stall      = 1'b0;
    bus.is_ie          = 1'b0;
    bus.is_exl         = 1'b0;
    bus.int_mask       = 8'h00;
    bus.soft_int       = 2'b00;
    bus.errorpc        = 32'h0;
    bus.redirect_ready = 1'b1;
    clearMem();

    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 128'(0));
    rst = 1'b0;

    // Syscall held off by stall, then taken.
    @(negedge clk);
    applyStimulus(32'hBFC0_0100, 32'h0, 1'b0, F_SYS);
    bus.mem_stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("stall_no_exc", 128'({bus.is_exception, bus.flush}), 128'(0));
    end
    bus.mem_stall = 1'b0;
    @(negedge clk);
    checkOutput("sys_exc", 128'(bus.is_exception), 128'(1));
    checkOutput("sys_code", 128'(bus.exc_code), 128'(8));
    checkOutput("sys_pc", 128'(bus.exc_pc), 128'(32'hBFC0_0100));
    checkOutput("sys_we_bad", 128'(bus.we_badvaddr), 128'(0));
    checkOutput("sys_flush", 128'(bus.flush), 128'(1));
    checkOutput("sys_eret", 128'(bus.is_excep_return), 128'(0));
    clearMem();
    expectRedirect("sys", 32'hBFC0_0380);

    // AdES from a delay-slot store.
    applyStimulus(32'hBFC0_0204, 32'h8000_0002, 1'b1, F_ADES);
    @(negedge clk);
    checkOutput("ades_code", 128'(bus.exc_code), 128'(5));
    checkOutput("ades_pc", 128'(bus.exc_pc), 128'(32'hBFC0_0200));
    checkOutput("ades_bd", 128'(bus.is_bd), 128'(1));
    checkOutput("ades_bad", 128'(bus.badvaddr), 128'(32'h8000_0002));
    checkOutput("ades_we_bad", 128'(bus.we_badvaddr), 128'(1));
    clearMem();
    @(negedge clk);
    checkOutput("ades_strobes_drop", 128'({bus.is_bd, bus.we_badvaddr}), 128'(0));
    repeat (2) @(negedge clk);
    checkOutput("ades_idle", 128'({bus.flush, bus.redirect_valid}), 128'(0));

    // Interrupt synchronisation and acceptance.
    bus.int_mask = 8'h04;
    bus.is_ie    = 1'b1;
    bus.is_exl   = 1'b0;
    bus.ext_int  = 6'h01;
    @(negedge clk);
    checkOutput("int_sync_1cyc", 128'(bus.hardware_int), 128'(0));
    @(negedge clk);
    checkOutput("int_sync_2cyc", 128'(bus.hardware_int), 128'(6'h01));
    checkOutput("int_no_valid", 128'(bus.flush), 128'(0));
    applyStimulus(32'h8000_0100, 32'h0, 1'b0, F_NONE);
    @(negedge clk);
    checkOutput("int_exc", 128'(bus.is_exception), 128'(1));
    checkOutput("int_code", 128'(bus.exc_code), 128'(0));
    checkOutput("int_pc", 128'(bus.exc_pc), 128'(32'h8000_0100));
    clearMem();
    expectRedirect("int", 32'hBFC0_0380);

    // Same interrupt masked by EXL.
    bus.is_exl = 1'b1;
    applyStimulus(32'h8000_0200, 32'h0, 1'b0, F_NONE);
    repeat (2) begin
      @(negedge clk);
      checkOutput("exl_no_exc", 128'({bus.is_exception, bus.flush}), 128'(0));
    end
    clearMem();
    bus.ext_int  = 6'h00;
    bus.int_mask = 8'h00;
    bus.is_ie    = 1'b0;
    bus.is_exl   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("int_deassert", 128'(bus.hardware_int), 128'(0));

    // Priority ordering.
    applyStimulus(32'h8000_0300, 32'h0, 1'b0, F_RI | F_OV | F_SYS);
    @(negedge clk);
    checkOutput("prio_ri", 128'(bus.exc_code), 128'(10));
    clearMem();
    expectRedirect("prio_ri", 32'hBFC0_0380);

    applyStimulus(32'h8000_0304, 32'h0, 1'b0, F_OV | F_SYS);
    @(negedge clk);
    checkOutput("prio_ov", 128'(bus.exc_code), 128'(12));
    clearMem();
    expectRedirect("prio_ov", 32'hBFC0_0380);

    applyStimulus(32'h8000_0401, 32'h1234_5678, 1'b0, F_ADEL_IF | F_RI);
    @(negedge clk);
    checkOutput("prio_adel_if", 128'(bus.exc_code), 128'(4));
    checkOutput("adel_if_bad", 128'(bus.badvaddr), 128'(32'h8000_0401));
    checkOutput("adel_if_we", 128'(bus.we_badvaddr), 128'(1));
    clearMem();
    expectRedirect("prio_adel_if", 32'hBFC0_0380);

    applyStimulus(32'h8000_0500, 32'h8000_0011, 1'b0, F_ADEL_LD | F_ADES);
    @(negedge clk);
    checkOutput("prio_adel_ld", 128'(bus.exc_code), 128'(4));
    checkOutput("adel_ld_bad", 128'(bus.badvaddr), 128'(32'h8000_0011));
    clearMem();
    expectRedirect("prio_adel_ld", 32'hBFC0_0380);

    applyStimulus(32'h8000_0600, 32'h8000_0022, 1'b0, F_BP | F_ADES | F_ERET);
    @(negedge clk);
    checkOutput("prio_bp", 128'(bus.exc_code), 128'(9));
    checkOutput("bp_no_eret", 128'(bus.is_excep_return), 128'(0));
    checkOutput("bp_we_bad", 128'(bus.we_badvaddr), 128'(0));
    clearMem();
    expectRedirect("prio_bp", 32'hBFC0_0380);

    // eret with back-pressure from fetch.
    bus.errorpc        = 32'h8000_1234;
    bus.redirect_ready = 1'b0;
    applyStimulus(32'h8000_0700, 32'h0, 1'b0, F_ERET);
    @(negedge clk);
    checkOutput("eret_ret", 128'(bus.is_excep_return), 128'(1));
    checkOutput("eret_no_exc", 128'(bus.is_exception), 128'(0));
    checkOutput("eret_flush", 128'(bus.flush), 128'(1));
    clearMem();
    bus.errorpc = 32'h0;
    @(negedge clk);
    checkOutput("eret_ret_drop", 128'(bus.is_excep_return), 128'(0));
    @(negedge clk);
    checkOutput("eret_valid", 128'(bus.redirect_valid), 128'(1));
    checkOutput("eret_pc", 128'(bus.redirect_pc), 128'(32'h8000_1234));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("eret_stall", 128'({bus.redirect_valid, bus.flush, bus.redirect_pc}),
                  128'({1'b1, 1'b1, 32'h8000_1234}));
    end
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    checkOutput("eret_idle", 128'({bus.flush, bus.redirect_valid}), 128'(0));

    // Asynchronous reset in the middle of a flush.
    applyStimulus(32'hBFC0_0100, 32'h0, 1'b0, F_SYS);
    @(negedge clk);
    checkOutput("pre_rst_flush", 128'(bus.flush), 128'(1));
    clearMem();
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", allOutputs(), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_quiet", allOutputs(), 128'(0));
    applyStimulus(32'hBFC0_0100, 32'h0, 1'b0, F_SYS);
    @(negedge clk);
    checkOutput("post_rst_exc", 128'(bus.is_exception), 128'(1));
    checkOutput("post_rst_code", 128'(bus.exc_code), 128'(8));
    clearMem();
    expectRedirect("post_rst", 32'hBFC0_0380);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
